// File: rtl/cla144_pipe_adder_pkg.sv
// Shared constants and types for the 144-bit pipelined carry-lookahead adder.
//   CLA_WIDTH : operand width (CLA_GRP_W * CLA_GRP_N)
//   CLA_GRP_W : bits per lookahead group
//   CLA_GRP_N : number of lookahead groups
//   grp_gp_t  : group generate/propagate pair
package fftc_cla_pkg;

  localparam int CLA_WIDTH = 144;
  localparam int CLA_GRP_W = 24;
  localparam int CLA_GRP_N = 6;

  typedef struct packed {
    logic g;
    logic p;
  } grp_gp_t;

endpackage

// File: rtl/cla144_pipe_adder_if.sv
// Operand/result stream bundle for cla144_pipe_adder.
//   in_valid/in_ready   : operand beat handshake
//   in_sub, in_a, in_b  : mode and operands; c_in carry-in (add mode only)
//   out_valid/out_ready : result handshake
//   sum, c_out          : result and carry out of the top bit
//   g_out, p_out        : whole-word generate/propagate for cascading
// master drives operands and out_ready; slave is the adder.
interface cla144_pipe_adder_if #(
  parameter int WIDTH = fftc_cla_pkg::CLA_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic             in_sub;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             g_out;
  logic             p_out;

  modport master (
    output in_valid, in_sub, in_a, in_b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, g_out, p_out
  );

  modport slave (
    input  in_valid, in_sub, in_a, in_b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, g_out, p_out
  );

endinterface

// File: rtl/cla144_pipe_adder_cla24_grp.sv
// One carry-lookahead group.
//   p, g     : per-bit propagate (a^b) and generate (a&b)
//   c_grp_in : carry into the group's lowest bit
//   gp       : group generate/propagate (independent of c_grp_in)
//   sum      : group sum bits given c_grp_in
// The first pipeline stage consumes gp only; the second consumes sum only.
module cla24_grp
  import fftc_cla_pkg::*;
#(
  parameter int GRP_W = CLA_GRP_W
) (
  input  logic [GRP_W-1:0] p,
  input  logic [GRP_W-1:0] g,
  input  logic             c_grp_in,
  output grp_gp_t          gp,
  output logic [GRP_W-1:0] sum
);

  always_comb begin : gp_tree
    logic g_acc;
    logic p_acc;
    gp    = '0;
    g_acc = g[0];
    p_acc = p[0];
    for (int i = 1; i < GRP_W; i++) begin
      g_acc = g[i] | (p[i] & g_acc);
      p_acc = p_acc & p[i];
    end
    gp.g = g_acc;
    gp.p = p_acc;
  end

  always_comb begin : sum_chain
    logic cy;
    sum = '0;
    cy  = c_grp_in;
    for (int i = 0; i < GRP_W; i++) begin
      sum[i] = p[i] ^ cy;
      cy     = g[i] | (p[i] & cy);
    end
  end

endmodule

// File: rtl/cla144_pipe_adder.sv
// Two-stage pipelined 144-bit carry-lookahead adder/subtractor.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (flushes both stages)
//   bus   : slave side of cla144_pipe_adder_if (operand and result streams)
// Stage 1 registers operands plus per-group G/P; stage 2 resolves the six
// group carries as flat sum-of-products and registers the result.
// Ready propagates combinationally back from out_ready (no skid buffer).
module cla144_pipe_adder
  import fftc_cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GRP_W = CLA_GRP_W,
  parameter int GRP_N = CLA_GRP_N
) (
  input  logic               clk,
  input  logic               rst_n,
  cla144_pipe_adder_if.slave bus
);

  logic adv1, adv2, take;
  logic vld_p1, vld_p2;

  assign adv2         = ~vld_p2 | bus.out_ready;
  assign adv1         = ~vld_p1 | adv2;
  assign bus.in_ready = adv1;
  assign take         = bus.in_valid & adv1;

  // ---- stage 0 -> 1: operand conditioning and group G/P ----
  logic [WIDTH-1:0] b_eff_p0, p_p0, g_p0;
  logic [WIDTH-1:0] unused_sum_p0;
  logic             cin_eff_p0;
  grp_gp_t          gp_p0 [GRP_N];

  assign b_eff_p0   = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign cin_eff_p0 = bus.in_sub | bus.c_in;
  assign p_p0       = bus.in_a ^ b_eff_p0;
  assign g_p0       = bus.in_a & b_eff_p0;

  for (genvar k = 0; k < GRP_N; k++) begin : g_s1
    cla24_grp #(.GRP_W(GRP_W)) u_grp (
      .p        (p_p0[k*GRP_W +: GRP_W]),
      .g        (g_p0[k*GRP_W +: GRP_W]),
      .c_grp_in (1'b0),
      .gp       (gp_p0[k]),
      .sum      (unused_sum_p0[k*GRP_W +: GRP_W])
    );
  end

  logic [WIDTH-1:0] a_p1, b_p1;
  logic             cin_p1;
  logic [GRP_N-1:0] gg_p1, pg_p1;

  always_ff @(posedge clk) begin
    if (take) begin
      a_p1   <= bus.in_a;
      b_p1   <= b_eff_p0;
      cin_p1 <= cin_eff_p0;
      for (int k = 0; k < GRP_N; k++) begin
        gg_p1[k] <= gp_p0[k].g;
        pg_p1[k] <= gp_p0[k].p;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv1) vld_p1 <= bus.in_valid;
      if (adv2) vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1 -> 2: group carries and sum ----
  logic [WIDTH-1:0] p_p1, g_p1, sum_p1;
  logic [GRP_N:0]   c_grp;
  logic             g_all;
  grp_gp_t          unused_gp_p1 [GRP_N];

  assign p_p1 = a_p1 ^ b_p1;
  assign g_p1 = a_p1 & b_p1;

  // Each group carry is expanded to G_k | P_k G_k-1 | ... | P_k..P_0 cin,
  // so no carry depends on another carry.
  always_comb begin : grp_carry
    logic carry_acc;
    logic prop_acc;
    c_grp     = '0;
    g_all     = 1'b0;
    carry_acc = 1'b0;
    prop_acc  = 1'b0;
    c_grp[0]  = cin_p1;
    for (int k = 0; k < GRP_N; k++) begin
      carry_acc = gg_p1[k];
      prop_acc  = pg_p1[k];
      for (int j = k - 1; j >= 0; j--) begin
        carry_acc = carry_acc | (prop_acc & gg_p1[j]);
        prop_acc  = prop_acc & pg_p1[j];
      end
      if (k == GRP_N - 1) g_all = carry_acc;
      c_grp[k+1] = carry_acc | (prop_acc & cin_p1);
    end
  end

  for (genvar k = 0; k < GRP_N; k++) begin : g_s2
    cla24_grp #(.GRP_W(GRP_W)) u_grp (
      .p        (p_p1[k*GRP_W +: GRP_W]),
      .g        (g_p1[k*GRP_W +: GRP_W]),
      .c_grp_in (c_grp[k]),
      .gp       (unused_gp_p1[k]),
      .sum      (sum_p1[k*GRP_W +: GRP_W])
    );
  end

  logic [WIDTH-1:0] sum_p2;
  logic             c_out_p2, g_out_p2, p_out_p2;

  // Loading only on a valid stage-1 beat keeps never-written stage-1 data
  // from reaching the output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p2   <= '0;
      c_out_p2 <= 1'b0;
      g_out_p2 <= 1'b0;
      p_out_p2 <= 1'b0;
    end else if (adv2 && vld_p1) begin
      sum_p2   <= sum_p1;
      c_out_p2 <= c_grp[GRP_N];
      g_out_p2 <= g_all;
      p_out_p2 <= &pg_p1;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.sum       = sum_p2;
  assign bus.c_out     = c_out_p2;
  assign bus.g_out     = g_out_p2;
  assign bus.p_out     = p_out_p2;

endmodule

// File: tb/tb_cla144_pipe_adder.sv
// Scoreboard bench for cla144_pipe_adder: expected results are computed with
// plain wide arithmetic when a beat is accepted and compared on emission.
module tb_cla144_pipe_adder;
  import fftc_cla_pkg::*;

  localparam int W = CLA_WIDTH;

  logic clk;
  logic rst_n;

  cla144_pipe_adder_if bus ();

  cla144_pipe_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         c_out;
    logic         g_out;
    logic         p_out;
    int           acc_cyc;
    bit           lat_chk;
  } exp_t;

  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic         drv_valid = 1'b0;
  logic         drv_sub   = 1'b0;
  logic         drv_cin   = 1'b0;
  logic         drv_ready = 1'b1;
  logic [W-1:0] drv_a     = '0;
  logic [W-1:0] drv_b     = '0;

  bit           acc_flag;
  bit           lat_mode;
  bit           held;
  logic [W-1:0] held_sum;

  task automatic chk_eq(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin);
    exp_t       e;
    logic [W-1:0] be;
    logic [W:0]   full;
    logic [W:0]   gen;
    be   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub | cin)};
    gen  = {1'b0, a} + {1'b0, be};
    e.sum     = full[W-1:0];
    e.c_out   = full[W];
    e.g_out   = gen[W];
    e.p_out   = &(a ^ be);
    e.acc_cyc = 0;
    e.lat_chk = 1'b0;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [159:0] r;
    int           sel;
    r   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    sel = $urandom_range(0, 7);
    if (sel == 0) r = '1;
    else if (sel == 1) r = '0;
    return r[W-1:0];
  endfunction

  // One clock: drive at the falling edge, sample handshakes 1 unit later.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    bus.in_valid  = drv_valid;
    bus.in_sub    = drv_sub;
    bus.in_a      = drv_a;
    bus.in_b      = drv_b;
    bus.c_in      = drv_cin;
    bus.out_ready = drv_ready;
    #1;
    cyc++;
    acc_flag = bus.in_valid & bus.in_ready;
    if (bus.out_valid & bus.out_ready) begin
      if (sb.size() == 0) begin
        chk_eq("spurious_out", bus.out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        chk_eq("sum", bus.sum, e.sum);
        chk_eq("c_out", bus.c_out, e.c_out);
        chk_eq("g_out", bus.g_out, e.g_out);
        chk_eq("p_out", bus.p_out, e.p_out);
        if (e.lat_chk) chk_eq("latency", cyc - e.acc_cyc, 2);
      end
      held = 1'b0;
    end else if (bus.out_valid) begin
      if (held) chk_eq("hold_sum", bus.sum, held_sum);
      held     = 1'b1;
      held_sum = bus.sum;
    end
    if (acc_flag) begin
      e         = model(drv_a, drv_b, drv_sub, drv_cin);
      e.acc_cyc = cyc;
      e.lat_chk = lat_mode;
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sub, input logic cin);
    int n;
    drv_a     = a;
    drv_b     = b;
    drv_sub   = sub;
    drv_cin   = cin;
    drv_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc_flag && n < 200);
    if (!acc_flag) chk_eq("acc_timeout", acc_flag, 1'b1);
    drv_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk_eq("drain", sb.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cycle=%0d expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] one;
    logic [W-1:0] a_t;
    int           cnt;
    int           sent;
    int           lim;

    one           = 1;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sub    = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b1;
    held          = 1'b0;
    lat_mode      = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_out_valid", bus.out_valid, 1'b0);
    chk_eq("rst_sum", bus.sum, '0);
    chk_eq("rst_c_out", bus.c_out, 1'b0);
    chk_eq("rst_g_out", bus.g_out, 1'b0);
    chk_eq("rst_p_out", bus.p_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_eq("rst_in_ready", bus.in_ready, 1'b1);

    // add wrapping to zero
    send('1, '0, 1'b0, 1'b1);
    drain();

    // carry across each group boundary
    for (int k = 0; k < 5; k++) begin
      a_t = {{(W-24){1'b0}}, 24'hFFFFFF} << (24 * k);
      send(a_t, one << (24 * k), 1'b0, 1'b0);
    end
    drain();

    // subtract, with and without borrow (c_in ignored in sub mode)
    send(144'd5, 144'd7, 1'b1, 1'b0);
    send(144'd7, 144'd5, 1'b1, 1'b1);
    drain();

    // backpressure: two beats fill the pipe, third is held
    lat_mode  = 1'b0;
    drv_ready = 1'b0;
    send(144'h1111, 144'h2222, 1'b0, 1'b0);
    send(144'h3333, 144'h4444, 1'b1, 1'b0);
    drv_a     = 144'h5555;
    drv_b     = 144'h6666;
    drv_sub   = 1'b0;
    drv_cin   = 1'b1;
    drv_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_eq("bp_in_ready", bus.in_ready, 1'b0);
      chk_eq("bp_out_valid", bus.out_valid, 1'b1);
    end
    drv_ready = 1'b1;
    lim = 0;
    do begin
      tick();
      lim++;
    end while (!acc_flag && lim < 50);
    if (!acc_flag) chk_eq("bp_acc_timeout", acc_flag, 1'b1);
    drv_valid = 1'b0;
    drain();

    // reset with both stages full
    drv_ready = 1'b0;
    send(144'd123, 144'd456, 1'b0, 1'b0);
    send(144'd789, 144'd1, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    chk_eq("rst_pre_vld", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_eq("rst_mid_out_valid", bus.out_valid, 1'b0);
    chk_eq("rst_mid_sum", bus.sum, '0);
    sb.delete();
    held      = 1'b0;
    drv_ready = 1'b1;
    tick();
    tick();
    rst_n    = 1'b1;
    lat_mode = 1'b1;
    send(144'hABCDEF, 144'h123456, 1'b0, 1'b1);
    drain();

    // throughput with valid and ready held high
    cnt = 0;
    drv_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      drv_a     = rnd_op();
      drv_b     = rnd_op();
      drv_sub   = 1'($urandom_range(0, 1));
      drv_cin   = 1'($urandom_range(0, 1));
      drv_valid = 1'b1;
      tick();
      if (acc_flag) cnt++;
    end
    chk_eq("throughput", cnt, 30);
    drain();

    // random traffic
    lat_mode = 1'b0;
    sent = 0;
    lim  = 0;
    while (sent < 2000 && lim < 20000) begin
      drv_a     = rnd_op();
      drv_b     = rnd_op();
      drv_sub   = 1'($urandom_range(0, 1));
      drv_cin   = 1'($urandom_range(0, 1));
      drv_valid = ($urandom_range(0, 3) != 0);
      drv_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc_flag) sent++;
      lim++;
    end
    chk_eq("rand_sent", sent, 2000);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
